// File: rtl/leve2_muldiv.sv
// M-extension execute unit: MUL/MULH*/DIV*/REM* and the RV64 W forms.
// The multiply result is captured after MUL_STAGES cycles; the restoring divider produces one quotient bit per cycle.
module leve2_muldiv #(
   parameter int XLEN       = 64,
   parameter int TAG_W      = 5,
   parameter int MUL_STAGES = 2
) (
   input  logic             CLK,
   input  logic             RSTn,
   input  logic             IVALID,
   output logic             IREADY,
   input  logic [2:0]       IFUNCT3,
   input  logic             IWORD,
   input  logic [XLEN-1:0]  IRS1,
   input  logic [XLEN-1:0]  IRS2,
   input  logic [TAG_W-1:0] ITAG,
   output logic             OVALID,
   input  logic             OREADY,
   output logic [XLEN-1:0]  ORESULT,
   output logic [TAG_W-1:0] OTAG,
   input  logic             FLUSH,
   output logic             BUSY
);

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

   state_t            r_state, w_state_nxt;
   logic [1:0]        r_f3;
   logic              r_word, r_neg_q, r_neg_r;
   logic [XLEN-1:0]   r_a, r_b, r_quo, r_rem, r_dvs, r_res;
   logic [TAG_W-1:0]  r_tag;
   logic [7:0]        r_cnt;

   function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
      logic [XLEN-1:0] r;
      r       = {XLEN{v[31]}};
      r[31:0] = v;
      return r;
   endfunction

   function automatic logic [XLEN-1:0] zext32(input logic [31:0] v);
      logic [XLEN-1:0] r;
      r       = '0;
      r[31:0] = v;
      return r;
   endfunction

   // Accept-side decode: W operands are narrowed and re-extended so the datapath is always XLEN wide
   logic            w_acc, w_word, w_sgn, w_ill, w_divz, w_ovf, w_neg_a, w_neg_b;
   logic [XLEN-1:0] w_in_a, w_in_b, w_minneg, w_mag_a, w_mag_b, w_spec_res;

   assign w_acc    = IVALID & (r_state == S_IDLE) & ~FLUSH;
   assign w_word   = IWORD & (XLEN == 64);
   assign w_sgn    = ~IFUNCT3[0];
   assign w_in_a   = w_word ? (w_sgn ? sext32(IRS1[31:0]) : zext32(IRS1[31:0])) : IRS1;
   assign w_in_b   = w_word ? (w_sgn ? sext32(IRS2[31:0]) : zext32(IRS2[31:0])) : IRS2;
   assign w_ill    = w_word & (IFUNCT3 inside {3'b001, 3'b010, 3'b011});
   assign w_minneg = w_word ? sext32(32'h8000_0000) : {1'b1, {(XLEN-1){1'b0}}};
   assign w_divz   = (w_in_b == '0);
   assign w_ovf    = w_sgn & (&w_in_b) & (w_in_a == w_minneg);
   assign w_neg_a  = w_sgn & w_in_a[XLEN-1];
   assign w_neg_b  = w_sgn & w_in_b[XLEN-1];
   assign w_mag_a  = w_neg_a ? -w_in_a : w_in_a;
   assign w_mag_b  = w_neg_b ? -w_in_b : w_in_b;

   always_comb begin
      w_spec_res = '0;
      if (w_ill)
         w_spec_res = '0;
      else if (w_divz)
         w_spec_res = IFUNCT3[1] ? (w_word ? sext32(IRS1[31:0]) : IRS1) : '1;
      else if (w_ovf)
         w_spec_res = IFUNCT3[1] ? '0 : w_in_a;
   end

   // Full-width product modulo 2^(2*XLEN) gives the correct high half for every signedness mix
   logic [2*XLEN-1:0] w_ma, w_mb, w_prod;
   logic [XLEN-1:0]   w_mul_res;

   assign w_ma      = (r_f3 == 2'b01 || r_f3 == 2'b10) ? {{XLEN{r_a[XLEN-1]}}, r_a} : {{XLEN{1'b0}}, r_a};
   assign w_mb      = (r_f3 == 2'b01) ? {{XLEN{r_b[XLEN-1]}}, r_b} : {{XLEN{1'b0}}, r_b};
   assign w_prod    = w_ma * w_mb;
   assign w_mul_res = (r_f3 == 2'b00) ? (r_word ? sext32(w_prod[31:0]) : w_prod[XLEN-1:0])
                                      : w_prod[2*XLEN-1:XLEN];

   logic [XLEN:0]   w_sh, w_diff;
   logic [XLEN-1:0] w_q, w_r, w_qr, w_div_res;

   assign w_sh      = {r_rem, r_quo[XLEN-1]};
   assign w_diff    = w_sh - {1'b0, r_dvs};
   assign w_q       = r_neg_q ? -r_quo : r_quo;
   assign w_r       = r_neg_r ? -r_rem : r_rem;
   assign w_qr      = r_f3[1] ? w_r : w_q;
   assign w_div_res = r_word ? sext32(w_qr[31:0]) : w_qr;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: if (w_acc) begin
            if (w_ill)                       w_state_nxt = S_DONE;
            else if (!IFUNCT3[2])            w_state_nxt = S_MUL;
            else if (w_divz || w_ovf)        w_state_nxt = S_DONE;
            else                             w_state_nxt = S_DIV;
         end
         S_MUL:  if (r_cnt == '0) w_state_nxt = S_DONE;
         S_DIV:  if (r_cnt == '0) w_state_nxt = S_DONE;
         S_DONE: if (OREADY)      w_state_nxt = S_IDLE;
         default:                 w_state_nxt = S_IDLE;
      endcase
      if (FLUSH) w_state_nxt = S_IDLE;
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         r_f3 <= '0; r_word <= 1'b0; r_neg_q <= 1'b0; r_neg_r <= 1'b0;
         r_a <= '0; r_b <= '0; r_quo <= '0; r_rem <= '0; r_dvs <= '0;
         r_res <= '0; r_tag <= '0; r_cnt <= '0;
      end else if (w_acc) begin
         r_f3    <= IFUNCT3[1:0];
         r_word  <= w_word;
         r_tag   <= ITAG;
         r_a     <= w_in_a;
         r_b     <= w_in_b;
         r_neg_q <= w_neg_a ^ w_neg_b;
         r_neg_r <= w_neg_a;
         r_rem   <= '0;
         r_dvs   <= w_mag_b;
         r_quo   <= w_word ? (w_mag_a << (XLEN-32)) : w_mag_a;
         r_cnt   <= IFUNCT3[2] ? (w_word ? 8'd32 : 8'(XLEN)) : 8'(MUL_STAGES-1);
         if (w_ill || (IFUNCT3[2] && (w_divz || w_ovf)))
            r_res <= w_spec_res;
      end else if (!FLUSH) begin
         if (r_state == S_MUL) begin
            if (r_cnt == '0) r_res <= w_mul_res;
            else             r_cnt <= r_cnt - 8'd1;
         end else if (r_state == S_DIV) begin
            if (r_cnt != '0) begin
               r_cnt <= r_cnt - 8'd1;
               r_rem <= w_diff[XLEN] ? w_sh[XLEN-1:0] : w_diff[XLEN-1:0];
               r_quo <= {r_quo[XLEN-2:0], ~w_diff[XLEN]};
            end else begin
               r_res <= w_div_res;
            end
         end
      end
   end

   assign IREADY  = (r_state == S_IDLE);
   assign BUSY    = (r_state != S_IDLE);
   assign OVALID  = (r_state == S_DONE);
   assign ORESULT = r_res;
   assign OTAG    = r_tag;

endmodule

// File: tb/tb_leve2_muldiv.sv
// Directed-vector bench for leve2_muldiv (XLEN=64, MUL_STAGES=2).
// Latency is counted in rising edges after the accept edge until OVALID is seen.
module tb_leve2_muldiv;

   logic        CLK = 1'b0;
   logic        RSTn;
   logic        IVALID, IWORD, OREADY, FLUSH;
   logic [2:0]  IFUNCT3;
   logic [63:0] IRS1, IRS2;
   logic [4:0]  ITAG;
   logic        IREADY, OVALID, BUSY;
   logic [63:0] ORESULT;
   logic [4:0]  OTAG;

   int n_vec = 0;
   int n_err = 0;

   leve2_muldiv #(.XLEN(64), .TAG_W(5), .MUL_STAGES(2)) dut (
      .CLK(CLK), .RSTn(RSTn), .IVALID(IVALID), .IREADY(IREADY), .IFUNCT3(IFUNCT3),
      .IWORD(IWORD), .IRS1(IRS1), .IRS2(IRS2), .ITAG(ITAG), .OVALID(OVALID),
      .OREADY(OREADY), .ORESULT(ORESULT), .OTAG(OTAG), .FLUSH(FLUSH), .BUSY(BUSY)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic issue(input logic [2:0] f3, input logic w, input logic [63:0] a,
                        input logic [63:0] b, input logic [4:0] t);
      @(posedge CLK); #1;
      IVALID = 1'b1; IFUNCT3 = f3; IWORD = w; IRS1 = a; IRS2 = b; ITAG = t;
      @(posedge CLK); #1;
      IVALID = 1'b0;
   endtask

   task automatic run_op(input string nm, input logic [2:0] f3, input logic w,
                         input logic [63:0] a, input logic [63:0] b, input logic [4:0] t,
                         input logic [63:0] exp_res, input int exp_lat, input int hold);
      int lat;
      issue(f3, w, a, b, t);
      lat = 0;
      while (!OVALID && lat < 100) begin
         @(posedge CLK); #1;
         lat++;
      end
      chk({nm, ".lat"}, 64'(lat), 64'(exp_lat));
      chk({nm, ".res"}, ORESULT, exp_res);
      chk({nm, ".tag"}, {59'd0, OTAG}, {59'd0, t});
      for (int i = 0; i < hold; i++) begin
         @(posedge CLK); #1;
         chk({nm, ".hold_res"}, ORESULT, exp_res);
         chk({nm, ".hold_tag"}, {59'd0, OTAG}, {59'd0, t});
         chk({nm, ".hold_irdy"}, {63'd0, IREADY}, 64'd0);
         chk({nm, ".hold_ovld"}, {63'd0, OVALID}, 64'd1);
      end
      OREADY = 1'b1;
      @(posedge CLK); #1;
      OREADY = 1'b0;
      chk({nm, ".irdy_after"}, {63'd0, IREADY}, 64'd1);
   endtask

   task automatic chk_reset_vals(input string nm);
      chk({nm, ".ovalid"}, {63'd0, OVALID}, 64'd0);
      chk({nm, ".busy"},   {63'd0, BUSY},   64'd0);
      chk({nm, ".iready"}, {63'd0, IREADY}, 64'd1);
      chk({nm, ".oresult"}, ORESULT, 64'd0);
      chk({nm, ".otag"},   {59'd0, OTAG},   64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int spurious;
      RSTn = 1'b0; IVALID = 1'b0; IWORD = 1'b0; OREADY = 1'b0; FLUSH = 1'b0;
      IFUNCT3 = 3'd0; IRS1 = '0; IRS2 = '0; ITAG = '0;
      #23;
      chk_reset_vals("reset");
      @(negedge CLK);
      RSTn = 1'b1;

      // Multiply group
      run_op("mul",    3'b000, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd3, 64'hFFFF_FFFF_FFFF_FFEB, 2, 0);
      run_op("mulh",   3'b001, 1'b0, '1, '1, 5'd4, 64'd0, 2, 0);
      run_op("mulhu",  3'b011, 1'b0, '1, '1, 5'd5, 64'hFFFF_FFFF_FFFF_FFFE, 2, 0);
      run_op("mulhsu", 3'b010, 1'b0, '1, 64'd2, 5'd6, 64'hFFFF_FFFF_FFFF_FFFF, 2, 0);
      run_op("mulw",   3'b000, 1'b1, 64'h0000_0000_4000_0001, 64'd2, 5'd7, 64'hFFFF_FFFF_8000_0002, 2, 0);

      // Divide special cases resolve in the cycle after accept
      run_op("div_ovf",  3'b100, 1'b0, 64'h8000_0000_0000_0000, '1, 5'd8, 64'h8000_0000_0000_0000, 0, 0);
      run_op("rem_ovf",  3'b110, 1'b0, 64'h8000_0000_0000_0000, '1, 5'd9, 64'd0, 0, 0);
      run_op("divu_z",   3'b101, 1'b0, 64'd5, 64'd0, 5'd10, '1, 0, 0);
      run_op("remu_z",   3'b111, 1'b0, 64'd5, 64'd0, 5'd11, 64'd5, 0, 0);
      run_op("ill_w",    3'b001, 1'b1, 64'd9, 64'd3, 5'd12, 64'd0, 0, 0);

      // W divides: 32 iterations plus fixup
      run_op("divw",  3'b100, 1'b1, 64'd20, 64'hFFFF_FFFF_FFFF_FFFA, 5'd13, 64'hFFFF_FFFF_FFFF_FFFD, 33, 0);
      run_op("remw",  3'b110, 1'b1, 64'd20, 64'hFFFF_FFFF_FFFF_FFFA, 5'd14, 64'd2, 33, 0);
      run_op("divuw", 3'b101, 1'b1, 64'hFFFF_FFFF, 64'd1, 5'd15, 64'hFFFF_FFFF_FFFF_FFFF, 33, 0);

      // Full-width divides: 64 iterations plus fixup
      run_op("div64",  3'b100, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 5'd16, 64'hFFFF_FFFF_FFFF_FFF2, 65, 0);
      run_op("rem64",  3'b110, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 5'd17, 64'hFFFF_FFFF_FFFF_FFFE, 65, 0);
      run_op("remu64", 3'b111, 1'b0, 64'd100, 64'd7, 5'd18, 64'd2, 65, 0);

      // Backpressure: result held for 5 cycles with OREADY low
      run_op("bp", 3'b000, 1'b0, 64'd6, 64'd7, 5'd19, 64'd42, 2, 5);

      // FLUSH in IDLE blocks the accept
      @(posedge CLK); #1;
      IVALID = 1'b1; FLUSH = 1'b1; IFUNCT3 = 3'b000; IRS1 = 64'd1; IRS2 = 64'd1;
      @(posedge CLK); #1;
      IVALID = 1'b0; FLUSH = 1'b0;
      chk("flush_idle.busy", {63'd0, BUSY}, 64'd0);

      // FLUSH on iteration 10 of a 64-bit divide
      issue(3'b100, 1'b0, 64'd1000, 64'd3, 5'd20);
      repeat (9) @(posedge CLK);
      #1 FLUSH = 1'b1;
      @(posedge CLK); #1;
      FLUSH = 1'b0;
      chk("flush_div.iready", {63'd0, IREADY}, 64'd1);
      chk("flush_div.busy",   {63'd0, BUSY},   64'd0);
      spurious = 0;
      for (int i = 0; i < 80; i++) begin
         @(posedge CLK); #1;
         if (OVALID) spurious++;
      end
      chk("flush_div.no_ovalid", 64'(spurious), 64'd0);
      run_op("mul_after_flush", 3'b000, 1'b0, 64'd11, 64'd13, 5'd21, 64'd143, 2, 0);

      // Asynchronous reset mid-divide
      issue(3'b101, 1'b0, 64'd12345, 64'd17, 5'd22);
      repeat (20) @(posedge CLK);
      #3 RSTn = 1'b0;
      #1;
      chk_reset_vals("async_rst");
      @(negedge CLK);
      RSTn = 1'b1;
      spurious = 0;
      for (int i = 0; i < 70; i++) begin
         @(posedge CLK); #1;
         if (OVALID) spurious++;
      end
      chk("async_rst.no_ovalid", 64'(spurious), 64'd0);
      run_op("mul_after_rst", 3'b011, 1'b0, 64'h8000_0000_0000_0000, 64'd4, 5'd23, 64'd2, 2, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
